sata_txfifo_sched: RTL and testbench

- Transmit-side scheduler that drains a synchronous data FIFO (asynchronous-read, first-word-fall-through) into the SATA link-layer data stream.
- Splits a host-requested transfer of N words into DATA FIS-sized frames of at most MAXFR words.
- Holds each frame until the FIFO holds enough data to avoid mid-frame underflow.
- Inserts a fixed inter-frame gap and reports completion or abort to the command layer.

---
 rtl/sata_txfifo_sched_if.sv | 40 ++++
 rtl/sata_txfifo_sched.sv | 145 ++++++++++++++
 tb/tb_sata_txfifo_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sata_txfifo_sched_if.sv
// Command, FIFO-head and link-stream signals of the SATA TX scheduler.
// master = scheduler side, slave = command layer / FIFO / link side.
interface sata_txfifo_sched_if #(
    parameter int DW     = 32,
    parameter int LGFLEN = 9,
    parameter int LGLEN  = 16
);
    logic              i_start;
    logic [LGLEN-1:0]  i_len;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_fifo_rd;
    logic              i_fifo_empty;
    logic [LGFLEN:0]   i_fifo_fill;
    logic [DW-1:0]     i_fifo_data;
    logic              o_valid;
    logic              i_ready;
    logic [DW-1:0]     o_data;
    logic              o_last;

    modport master (
        input  i_start, i_len, i_abort,
        output o_busy, o_done, o_err,
        output o_fifo_rd,
        input  i_fifo_empty, i_fifo_fill, i_fifo_data,
        output o_valid, o_data, o_last,
        input  i_ready
    );

    modport slave (
        output i_start, i_len, i_abort,
        input  o_busy, o_done, o_err,
        input  o_fifo_rd,
        output i_fifo_empty, i_fifo_fill, i_fifo_data,
        input  o_valid, o_data, o_last,
        output i_ready
    );
endinterface

// File: rtl/sata_txfifo_sched.sv
// SATA TX scheduler: drains a FWFT FIFO into DATA-FIS sized frames,
// starting each frame only once enough data is buffered, with a fixed gap.
module sata_txfifo_sched #(
    parameter int DW      = 32,
    parameter int LGFLEN  = 9,
    parameter int LGMAXFR = 11,
    parameter int LGLEN   = 16,
    parameter int GAP     = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    sata_txfifo_sched_if.master bus
);
    localparam int FW = LGMAXFR + 1;
    localparam int LW = (LGLEN > FW) ? LGLEN : FW;
    localparam int CW = (LGFLEN + 1 > FW) ? LGFLEN + 1 : FW;
    localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

    localparam logic [LW-1:0] MAXFR_L = LW'(1) << LGMAXFR;
    localparam logic [CW-1:0] CAP_C   = CW'(1) << LGFLEN;
    // The WAIT state itself is one idle cycle, so GAP holds GAP-1 cycles.
    localparam logic [GW-1:0] GAP_LD  = GW'((GAP > 1) ? GAP - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SEND,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [LGLEN-1:0] rem_q, rem_d;
    logic [FW-1:0]    frm_q, frm_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [CW-1:0]    frm_w;
    logic [CW-1:0]    thresh;
    logic             fill_ok;
    logic             valid_w;
    logic             beat_w;

    function automatic logic [FW-1:0] frame_of(input logic [LGLEN-1:0] n);
        logic [LW-1:0] w;
        w = LW'(n);
        frame_of = (w > MAXFR_L) ? MAXFR_L[FW-1:0] : w[FW-1:0];
    endfunction

    // Start threshold: whole frame, capped at the FIFO capacity.
    always_comb begin
        frm_w   = CW'(frm_q);
        thresh  = (frm_w > CAP_C) ? CAP_C : frm_w;
        fill_ok = (CW'(bus.i_fifo_fill) >= thresh);
    end

    // State and counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            frm_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            frm_q   <= frm_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter update; abort overrides everything.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        frm_d   = frm_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = bus.i_len;
                        frm_d   = frame_of(bus.i_len);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (fill_ok) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (beat_w) begin
                    rem_d = rem_q - LGLEN'(1);
                    frm_d = frm_q - FW'(1);
                    if (frm_q == FW'(1)) begin
                        if (rem_q == LGLEN'(1)) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frm_d   = frame_of(rem_q - LGLEN'(1));
                            gap_d   = GAP_LD;
                            state_d = (GAP > 1) ? S_GAP : S_WAIT;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_WAIT;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
        endcase
        if (bus.i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    // Stream, FIFO-strobe and status outputs.
    always_comb begin
        valid_w       = (state_q == S_SEND) && !bus.i_fifo_empty
                        && !bus.i_abort;
        beat_w        = valid_w && bus.i_ready;
        bus.o_valid   = valid_w;
        bus.o_fifo_rd = beat_w;
        bus.o_last    = valid_w && (frm_q == FW'(1));
        bus.o_data    = bus.i_fifo_data;
        bus.o_busy    = (state_q != S_IDLE);
        bus.o_done    = done_q;
        bus.o_err     = err_q;
    end
endmodule

// File: tb/tb_sata_txfifo_sched.sv
// Scoreboard bench for sata_txfifo_sched: FIFO model, directed transfers,
// monitor compares every beat and every done/err pulse.
module tb_sata_txfifo_sched;
    localparam int DW      = 32;
    localparam int LGFLEN  = 9;
    localparam int LGMAXFR = 11;
    localparam int LGLEN   = 16;
    localparam int GAP     = 2;
    localparam int DEPTH   = 1 << LGFLEN;
    localparam int MAXFR   = 1 << LGMAXFR;
    localparam int EV_NONE = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sata_txfifo_sched_if #(.DW(DW), .LGFLEN(LGFLEN), .LGLEN(LGLEN)) bus ();

    sata_txfifo_sched #(
        .DW(DW), .LGFLEN(LGFLEN), .LGMAXFR(LGMAXFR),
        .LGLEN(LGLEN), .GAP(GAP)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    int checks = 0;
    int errors = 0;
    logic [DW:0]   exp_q[$];
    int            evt_q[$];
    logic [DW-1:0] fifo[$];
    int            feed_left = 0;
    logic [DW-1:0] feed_next = '0;
    bit            pop_pend = 1'b0;
    int            beats = 0;
    int            cyc = 0;
    bit            gapchk = 1'b0;
    bit            after_last = 1'b0;
    int            last_cyc = 0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] hold_data;
    logic [DW:0]   e;
    logic          beat;
    int            want;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void fifo_drive();
        while (fifo.size() < DEPTH && feed_left > 0) begin
            fifo.push_back(feed_next);
            feed_next = feed_next + 1;
            feed_left--;
        end
        bus.i_fifo_fill  = (LGFLEN+1)'(fifo.size());
        bus.i_fifo_empty = (fifo.size() == 0);
        bus.i_fifo_data  = (fifo.size() != 0) ? fifo[0] : '0;
    endfunction

    function automatic void feed(int n);
        feed_left += n;
        fifo_drive();
    endfunction

    function automatic void clear_fifo();
        fifo.delete();
        feed_left = 0;
        pop_pend  = 1'b0;
        fifo_drive();
    endfunction

    function automatic void expect_xfer(int n, logic [DW-1:0] base);
        logic lst;
        for (int k = 0; k < n; k++) begin
            lst = (((k + 1) % MAXFR) == 0) || (k == n - 1);
            exp_q.push_back({lst, base + DW'(k)});
        end
        evt_q.push_back(EV_DONE);
    endfunction

    // FIFO model: pop the word the DUT accepted at the last edge, refill.
    always @(posedge clk) begin
        #1;
        if (pop_pend && fifo.size() != 0) begin
            void'(fifo.pop_front());
        end
        pop_pend = 1'b0;
        fifo_drive();
    end

    // Monitor: compare beats and status pulses against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            beat = bus.o_valid && bus.i_ready;
            check("rd_is_beat", bus.o_fifo_rd, beat);
            check("rd_when_empty", bus.o_fifo_rd && bus.i_fifo_empty, 0);
            if (hold_prev && !bus.i_abort) begin
                check("hold_valid", bus.o_valid, 1);
                check("hold_data", bus.o_data, hold_data);
            end
            hold_prev = bus.o_valid && !bus.i_ready;
            hold_data = bus.o_data;
            if (beat) begin
                beats++;
                pop_pend = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", bus.o_data, 'x);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", bus.o_data, e[DW-1:0]);
                    check("beat_last", bus.o_last, e[DW]);
                end
                if (gapchk && after_last) begin
                    check("gap_cycles", cyc - last_cyc, GAP + 1);
                end
                after_last = bus.o_last;
                if (bus.o_last) last_cyc = cyc;
            end
            if (bus.o_done || bus.o_err) begin
                want = (evt_q.size() != 0) ? evt_q.pop_front() : EV_NONE;
                check("event", bus.o_done ? EV_DONE : EV_ERR, want);
                check("busy_at_event", bus.o_busy, 0);
                check("done_and_err", bus.o_done && bus.o_err, 0);
            end
        end
    end

    task automatic start(int len);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_len   = LGLEN'(len);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(string nm, int budget);
        int n = 0;
        while ((bus.o_busy || evt_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_finished"}, n < budget, 1);
        check({nm, "_beats_left"}, exp_q.size(), 0);
        exp_q.delete();
        evt_q.delete();
    endtask

    task automatic wait_beats(string nm, int target, int budget);
        int n = 0;
        while (beats < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_beats_reached"}, n < budget, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_len   = '0;
        bus.i_abort = 1'b0;
        bus.i_ready = 1'b1;
        clear_fifo();
        repeat (2) @(negedge clk);
        check("rst_busy", bus.o_busy, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_rd_last", {bus.o_fifo_rd, bus.o_last}, 0);
        check("rst_done_err", {bus.o_done, bus.o_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // len 5 with 5 words buffered: one WAIT cycle, five beats, done
        clear_fifo();
        feed_next = 32'hA000_0000;
        feed(5);
        expect_xfer(5, 32'hA000_0000);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_len   = LGLEN'(5);
        @(negedge clk);
        check("t1_idle_busy", bus.o_busy, 0);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("t1_wait", {bus.o_busy, bus.o_valid}, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_beat_valid", bus.o_valid, 1);
        end
        @(negedge clk);
        check("t1_done", {bus.o_done, bus.o_busy}, 2'b10);
        wait_idle("t1", 10);

        // len 2050, FIFO kept full: 2048 + 2 frames with GAP idle cycles
        clear_fifo();
        feed_next = 32'hB000_0000;
        feed(2050);
        expect_xfer(2050, 32'hB000_0000);
        after_last = 1'b0;
        gapchk = 1'b1;
        start(2050);
        wait_idle("t2", 2200);
        gapchk = 1'b0;
        after_last = 1'b0;

        // len 4 with only 2 words: hold in WAIT until the 4th arrives
        clear_fifo();
        feed_next = 32'hC000_0000;
        feed(2);
        expect_xfer(4, 32'hC000_0000);
        start(4);
        repeat (4) begin
            @(negedge clk);
            check("t3_wait2", {bus.o_busy, bus.o_valid}, 2'b10);
        end
        @(posedge clk); #1;
        feed(1);
        repeat (3) begin
            @(negedge clk);
            check("t3_wait3", {bus.o_busy, bus.o_valid}, 2'b10);
        end
        @(posedge clk); #1;
        feed(1);
        wait_idle("t3", 20);

        // len 600, 512 buffered: FIFO drains mid-frame, stream stalls
        clear_fifo();
        feed_next = 32'hD000_0000;
        feed(512);
        expect_xfer(600, 32'hD000_0000);
        b0 = beats;
        start(600);
        wait_beats("t3s", b0 + 512, 700);
        repeat (5) begin
            @(negedge clk);
            check("t3s_stall", {bus.o_busy, bus.o_valid, bus.o_last}, 3'b100);
        end
        @(posedge clk); #1;
        feed(88);
        wait_idle("t3s", 200);
        check("t3s_beats", beats - b0, 600);

        // len 3 with HOLD on beat 2; a start during HOLD is ignored
        clear_fifo();
        feed_next = 32'hE000_0000;
        feed(3);
        expect_xfer(3, 32'hE000_0000);
        b0 = beats;
        start(3);
        wait_beats("t4", b0 + 1, 10);
        bus.i_ready = 1'b0;
        @(negedge clk);
        check("t4_hold", {bus.o_valid, bus.o_fifo_rd}, 2'b10);
        check("t4_hold_data", bus.o_data, 32'hE000_0001);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_len   = LGLEN'(7);
        @(negedge clk);
        check("t4_hold", {bus.o_valid, bus.o_fifo_rd}, 2'b10);
        check("t4_hold_data", bus.o_data, 32'hE000_0001);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("t4_hold", {bus.o_valid, bus.o_fifo_rd}, 2'b10);
        check("t4_hold_data", bus.o_data, 32'hE000_0001);
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        wait_idle("t4", 20);
        check("t4_beats", beats - b0, 3);

        // abort after beat 10 of len 100, then a clean len-1 transfer
        clear_fifo();
        feed_next = 32'hF000_0000;
        feed(100);
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back({1'b0, 32'hF000_0000 + DW'(k)});
        end
        evt_q.push_back(EV_ERR);
        b0 = beats;
        start(100);
        wait_beats("t5", b0 + 10, 40);
        bus.i_abort = 1'b1;
        @(negedge clk);
        check("t5_abort_cycle", {bus.o_valid, bus.o_fifo_rd}, 2'b00);
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        @(negedge clk);
        check("t5_err", {bus.o_err, bus.o_done, bus.o_busy}, 3'b100);
        @(negedge clk);
        check("t5_err_pulse", bus.o_err, 0);
        wait_idle("t5", 5);
        check("t5_beats", beats - b0, 10);
        @(posedge clk); #1;
        clear_fifo();
        feed_next = 32'h1234_5678;
        feed(1);
        expect_xfer(1, 32'h1234_5678);
        start(1);
        wait_idle("t5b", 10);

        // len 0: done next cycle, no beats
        b0 = beats;
        evt_q.push_back(EV_DONE);
        start(0);
        @(negedge clk);
        check("t6_done", {bus.o_done, bus.o_busy, bus.o_valid}, 3'b100);
        wait_idle("t6", 5);
        check("t6_beats", beats - b0, 0);

        // asynchronous reset mid-SEND clears outputs before any edge
        clear_fifo();
        feed_next = 32'h5500_0000;
        feed(20);
        expect_xfer(20, 32'h5500_0000);
        b0 = beats;
        start(20);
        wait_beats("t7", b0 + 3, 10);
        #2;
        rst = 1'b1;
        #1;
        check("t7_async", {bus.o_valid, bus.o_fifo_rd, bus.o_last, bus.o_busy}, 0);
        exp_q.delete();
        evt_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_fifo();
        feed_next = 32'h6600_0000;
        feed(2);
        expect_xfer(2, 32'h6600_0000);
        start(2);
        wait_idle("t7b", 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
